// File: rtl/sonic_distance_filter_if.sv
// Measurement-in / filtered-distance-out bundle for sonic_distance_filter.
interface sonic_distance_filter_if;
  logic [19:0] dist_in;
  logic        dist_tick;
  logic [19:0] dist_avg;
  logic        avg_valid;
  logic [1:0]  zone;
  logic        obstacle;
  logic        zone_change;
  logic        primed;

  modport master (
    output dist_in, dist_tick,
    input  dist_avg, avg_valid, zone, obstacle, zone_change, primed
  );

  modport slave (
    input  dist_in, dist_tick,
    output dist_avg, avg_valid, zone, obstacle, zone_change, primed
  );
endinterface

// File: rtl/sonic_distance_filter.sv
// Ultrasonic distance filter: drop/clamp, moving average, zone classification with hysteresis.
// Define MEDIAN3_EN to insert a 3-tap median stage after the clamp (+1 cycle latency).
module sonic_distance_filter #(
  parameter int unsigned LOG_DEPTH = 2,
  parameter int unsigned MAX_CM    = 400,
  parameter int unsigned NEAR_CM   = 15,
  parameter int unsigned FAR_CM    = 40,
  parameter int unsigned HYST_CM   = 5,
  parameter int unsigned CONFIRM   = 2
) (
  input logic                     clk,
  input logic                     rst,
  sonic_distance_filter_if.slave  bus
);
  localparam int unsigned DEPTH = 1 << LOG_DEPTH;
  localparam int unsigned SW    = 20 + LOG_DEPTH;

  typedef enum logic [1:0] {
    ZONE_CLEAR = 2'd0,
    ZONE_WARN  = 2'd1,
    ZONE_STOP  = 2'd2
  } zone_e;

  // Stage 0: drop no-echo samples and clamp
  logic        s0_valid_d, s0_valid_q;
  logic [19:0] s0_sample_d, s0_sample_q;

  always_comb begin
    s0_valid_d  = bus.dist_tick && (bus.dist_in != '0);
    s0_sample_d = s0_sample_q;
    if (s0_valid_d)
      s0_sample_d = (bus.dist_in > 20'(MAX_CM)) ? 20'(MAX_CM) : bus.dist_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid_q  <= 1'b0;
      s0_sample_q <= '0;
    end else begin
      s0_valid_q  <= s0_valid_d;
      s0_sample_q <= s0_sample_d;
    end
  end

  logic        s1_in_valid;
  logic [19:0] s1_in_sample;

`ifdef MEDIAN3_EN
  logic [19:0] tap0_d, tap0_q, tap1_d, tap1_q, m_sample_d, m_sample_q;
  logic        seeded_d, seeded_q, m_valid_d, m_valid_q;

  function automatic logic [19:0] med3(input logic [19:0] a, input logic [19:0] b,
                                       input logic [19:0] c);
    logic [19:0] lo, hi, mid;
    lo  = (a < b) ? a : b;
    hi  = (a < b) ? b : a;
    mid = (hi < c) ? hi : c;
    return (lo > mid) ? lo : mid;
  endfunction

  // First sample after reset seeds every tap so the median starts at that value
  always_comb begin
    tap0_d     = tap0_q;
    tap1_d     = tap1_q;
    seeded_d   = seeded_q;
    m_sample_d = m_sample_q;
    m_valid_d  = s0_valid_q;
    if (s0_valid_q) begin
      seeded_d = 1'b1;
      tap0_d   = s0_sample_q;
      if (!seeded_q) begin
        tap1_d     = s0_sample_q;
        m_sample_d = s0_sample_q;
      end else begin
        tap1_d     = tap0_q;
        m_sample_d = med3(s0_sample_q, tap0_q, tap1_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap0_q     <= '0;
      tap1_q     <= '0;
      seeded_q   <= 1'b0;
      m_sample_q <= '0;
      m_valid_q  <= 1'b0;
    end else begin
      tap0_q     <= tap0_d;
      tap1_q     <= tap1_d;
      seeded_q   <= seeded_d;
      m_sample_q <= m_sample_d;
      m_valid_q  <= m_valid_d;
    end
  end

  assign s1_in_valid  = m_valid_q;
  assign s1_in_sample = m_sample_q;
`else
  assign s1_in_valid  = s0_valid_q;
  assign s1_in_sample = s0_sample_q;
`endif

  // Stage 1: ring buffer and running sum
  logic [DEPTH-1:0][19:0] ring_d, ring_q;
  logic [SW-1:0]          sum_d, sum_q;
  logic [LOG_DEPTH-1:0]   wr_ptr_d, wr_ptr_q;
  logic [LOG_DEPTH:0]     fill_d, fill_q;
  logic                   primed_d, primed_q, s1_valid_d, s1_valid_q;

  always_comb begin
    ring_d     = ring_q;
    sum_d      = sum_q;
    wr_ptr_d   = wr_ptr_q;
    fill_d     = fill_q;
    primed_d   = primed_q;
    s1_valid_d = s1_in_valid;
    if (s1_in_valid) begin
      sum_d            = sum_q + SW'(s1_in_sample) - SW'(ring_q[wr_ptr_q]);
      ring_d[wr_ptr_q] = s1_in_sample;
      wr_ptr_d         = wr_ptr_q + LOG_DEPTH'(1);
      if (fill_q != (LOG_DEPTH+1)'(DEPTH))
        fill_d = fill_q + (LOG_DEPTH+1)'(1);
      primed_d = (fill_d == (LOG_DEPTH+1)'(DEPTH));
    end
  end

  // Stage 2: average
  logic [19:0] dist_avg_d, dist_avg_q;
  logic        avg_valid_d, avg_valid_q;

  always_comb begin
    avg_valid_d = s1_valid_q && primed_q;
    dist_avg_d  = dist_avg_q;
    if (avg_valid_d)
      dist_avg_d = 20'(sum_q >> LOG_DEPTH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ring_q      <= '0;
      sum_q       <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      primed_q    <= 1'b0;
      s1_valid_q  <= 1'b0;
      dist_avg_q  <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      ring_q      <= ring_d;
      sum_q       <= sum_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      primed_q    <= primed_d;
      s1_valid_q  <= s1_valid_d;
      dist_avg_q  <= dist_avg_d;
      avg_valid_q <= avg_valid_d;
    end
  end

  // Stage 3: zone confirm FSM
  zone_e       zone_d, zone_q, cand_d, cand_q, target;
  logic [3:0]  cnt_d, cnt_q;
  logic        zone_change_d, zone_change_q, obstacle_d, obstacle_q;

  always_comb begin
    target = ZONE_CLEAR;
    case (zone_q)
      ZONE_CLEAR: begin
        if (dist_avg_q < 20'(NEAR_CM))     target = ZONE_STOP;
        else if (dist_avg_q < 20'(FAR_CM)) target = ZONE_WARN;
        else                               target = ZONE_CLEAR;
      end
      ZONE_WARN: begin
        if (dist_avg_q < 20'(NEAR_CM))                target = ZONE_STOP;
        else if (dist_avg_q >= 20'(FAR_CM + HYST_CM)) target = ZONE_CLEAR;
        else                                          target = ZONE_WARN;
      end
      ZONE_STOP: begin
        if (dist_avg_q >= 20'(FAR_CM + HYST_CM))       target = ZONE_CLEAR;
        else if (dist_avg_q >= 20'(NEAR_CM + HYST_CM)) target = ZONE_WARN;
        else                                           target = ZONE_STOP;
      end
      default: target = ZONE_CLEAR;
    endcase

    zone_d = zone_q;
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (avg_valid_q) begin
      if (target == zone_q) begin
        cnt_d = '0;
      end else begin
        if (target == cand_q) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          cand_d = target;
          cnt_d  = 4'd1;
        end
        if (cnt_d == 4'(CONFIRM)) begin
          zone_d = cand_d;
          cnt_d  = '0;
        end
      end
    end
  end

  // A commit always moves to a different zone, so a zone difference marks the change
  always_comb begin
    zone_change_d = (zone_d != zone_q);
    obstacle_d    = obstacle_q;
    if (zone_change_d)
      obstacle_d = (zone_d == ZONE_STOP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zone_q        <= ZONE_CLEAR;
      cand_q        <= ZONE_CLEAR;
      cnt_q         <= '0;
      zone_change_q <= 1'b0;
      obstacle_q    <= 1'b0;
    end else begin
      zone_q        <= zone_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      zone_change_q <= zone_change_d;
      obstacle_q    <= obstacle_d;
    end
  end

  assign bus.dist_avg    = dist_avg_q;
  assign bus.avg_valid   = avg_valid_q;
  assign bus.zone        = zone_q;
  assign bus.obstacle    = obstacle_q;
  assign bus.zone_change = zone_change_q;
  assign bus.primed      = primed_q;
endmodule
